// File: rtl/turret_pkg.sv
// turret_pkg: shared types, defaults and helpers
// for the pan/tilt servo pulse sequencer.
package turret_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPD0,
    UPD1
  } state_e;

  localparam bit PAN  = 1'b0;
  localparam bit TILT = 1'b1;

  localparam int MIN_US_D    = 1000;
  localparam int MAX_US_D    = 2000;
  localparam int CENTER_US_D = 1500;
  localparam int STEP_US_D   = 10;

  function automatic logic [31:0] clamp(
    input logic [31:0] v,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// pwm_frame_timer: 1 us tick prescaler plus
// frame counter; free-running, never gated.
module pwm_frame_timer #(
  parameter int CLK_DIV  = 10,
  parameter int FRAME_US = 20000,
  parameter int W        = 16
) (
  input  logic         SYSCLK,
  input  logic         NSYSRESET,
  output logic         tick,
  output logic [W-1:0] frame_cnt,
  output logic         wrap
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  frame_q, frame_d;

  // next prescaler / frame count
  always_comb begin
    tick    = presc_q == PW'(CLK_DIV - 1);
    wrap    = tick && (frame_q == W'(FRAME_US - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    frame_d = frame_q;
    if (wrap) frame_d = '0;
    else if (tick) frame_d = frame_q + 1'b1;
  end

  // timebase registers
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      presc_q <= '0;
      frame_q <= '0;
    end else begin
      presc_q <= presc_d;
      frame_q <= frame_d;
    end
  end

  assign frame_cnt = frame_q;

endmodule

// File: rtl/turret_servo_sequencer.sv
// turret_servo_sequencer: two-channel servo PWM
// with per-frame bounded slew toward targets.
module turret_servo_sequencer
  import turret_pkg::*;
#(
  parameter int CLK_DIV   = 10,
  parameter int FRAME_US  = 20000,
  parameter int MIN_US    = MIN_US_D,
  parameter int MAX_US    = MAX_US_D,
  parameter int CENTER_US = CENTER_US_D,
  parameter int STEP_US   = STEP_US_D,
  parameter int W         = 16
) (
  input  logic         SYSCLK,
  input  logic         NSYSRESET,
  input  logic         enable,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_chan,
  input  logic [W-1:0] cmd_target,
  output logic         cmd_err,
  output logic [1:0]   pwm_out,
  output logic [1:0]   at_target,
  output logic         frame_strobe
);

  localparam logic [W-1:0] CENTER_W = W'(CENTER_US);
  localparam logic [W-1:0] STEP_W   = W'(STEP_US);
  localparam logic signed [W:0] STEP_S = (W+1)'(STEP_US);

  state_e state_q, state_d;
  logic [1:0][W-1:0] cur_q, cur_d;
  logic [1:0][W-1:0] tgt_q, tgt_d;
  logic [1:0] pwm_q, pwm_d;
  logic err_q, err_d;
  logic strobe_q, strobe_d;
  logic alive_q, alive_d;

  logic tick, wrap;
  logic [W-1:0] frame_cnt;
  logic sel, upd, acc;
  logic [W-1:0] cur_s, tgt_s, step_w, tgt_c;
  logic signed [W:0] diff;

  pwm_frame_timer #(
    .CLK_DIV (CLK_DIV),
    .FRAME_US(FRAME_US),
    .W       (W)
  ) u_timer (
    .SYSCLK   (SYSCLK),
    .NSYSRESET(NSYSRESET),
    .tick     (tick),
    .frame_cnt(frame_cnt),
    .wrap     (wrap)
  );

  assign upd = (state_q == UPD0) || (state_q == UPD1);
  assign sel = (state_q == UPD1);
  assign acc = cmd_valid && cmd_ready;
  assign tgt_c = W'(clamp(32'(cmd_target),
                          32'(MIN_US), 32'(MAX_US)));

  // shared slew step for the channel being updated
  always_comb begin
    cur_s  = cur_q[sel];
    tgt_s  = tgt_q[sel];
    diff   = $signed({1'b0, tgt_s}) - $signed({1'b0, cur_s});
    step_w = tgt_s;
    if (diff > STEP_S) step_w = cur_s + STEP_W;
    else if (diff < -STEP_S) step_w = cur_s - STEP_W;
  end

  // sequencer next state, command capture, pwm compare
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    alive_d  = 1'b1;
    strobe_d = wrap;
    err_d    = acc && (tgt_c != cmd_target);
    unique case (state_q)
      IDLE:    if (tick && wrap) state_d = UPD0;
      UPD0:    state_d = UPD1;
      UPD1:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (upd && enable) cur_d[sel] = step_w;
    if (acc) tgt_d[cmd_chan] = tgt_c;
    pwm_d[PAN]  = enable && (frame_cnt < cur_q[PAN]);
    pwm_d[TILT] = enable && (frame_cnt < cur_q[TILT]);
  end

  // state and datapath registers
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q  <= IDLE;
      cur_q    <= {2{CENTER_W}};
      tgt_q    <= {2{CENTER_W}};
      pwm_q    <= '0;
      err_q    <= 1'b0;
      strobe_q <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      pwm_q    <= pwm_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      alive_q  <= alive_d;
    end
  end

  assign cmd_ready    = alive_q && (state_q == IDLE);
  assign cmd_err      = err_q;
  assign pwm_out      = pwm_q;
  assign frame_strobe = strobe_q;
  assign at_target[PAN]  = cur_q[PAN] == tgt_q[PAN];
  assign at_target[TILT] = cur_q[TILT] == tgt_q[TILT];

endmodule

// File: tb/tb_turret_servo_sequencer.sv
// tb_turret_servo_sequencer: scoreboard bench; per-frame
// pwm high counts and cmd_err checked by a monitor.
module tb_turret_servo_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_chan;
  logic [W-1:0] cmd_target;
  logic         cmd_err;
  logic [1:0]   pwm_out;
  logic [1:0]   at_target;
  logic         frame_strobe;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    int         h0;
    int         h1;
    logic [1:0] at;
  } frame_exp_t;

  frame_exp_t fq[$];
  bit         eq[$];

  turret_servo_sequencer #(
    .CLK_DIV  (4),
    .FRAME_US (100),
    .MIN_US   (10),
    .MAX_US   (60),
    .CENTER_US(35),
    .STEP_US  (5),
    .W        (W)
  ) dut (
    .SYSCLK      (clk),
    .NSYSRESET   (rst_n),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_chan    (cmd_chan),
    .cmd_target  (cmd_target),
    .cmd_err     (cmd_err),
    .pwm_out     (pwm_out),
    .at_target   (at_target),
    .frame_strobe(frame_strobe)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    tot_cnt++;
    if (got !== want)
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    else
      pass_cnt++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int h0, input int h1,
                            input logic [1:0] at);
    frame_exp_t e;
    e.h0 = h0;
    e.h1 = h1;
    e.at = at;
    fq.push_back(e);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 1000);
    if (!frame_strobe) chk("strobe_timeout", 0, 1);
  endtask

  task automatic frame(input int h0, input int h1,
                       input logic [1:0] at);
    int n;
    push_frame(h0, h1, at);
    wait_strobe(n);
  endtask

  task automatic release_rst();
    int n;
    nxt();
    rst_n = 1'b1;
    wait_strobe(n);
    chk("first_strobe_cycles", n, 401);
  endtask

  task automatic send_cmd(input bit ch, input int tg,
                          input bit e);
    int n;
    eq.push_back(e);
    nxt();
    cmd_valid  = 1'b1;
    cmd_chan   = ch;
    cmd_target = W'(tg);
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        chk("cmd_ready_timeout", 0, 1);
        break;
      end
    end
    nxt();
    cmd_valid = 1'b0;
  endtask

  // monitor: scores each frame and each handshake
  initial begin
    int c0, c1;
    bit upd1_chk, pend, pend_e;
    frame_exp_t e;
    c0 = 0; c1 = 0; upd1_chk = 0; pend = 0; pend_e = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c0 = 0; c1 = 0; upd1_chk = 0; pend = 0;
      end else begin
        if (upd1_chk) begin
          chk("ready_upd1", cmd_ready, 0);
          upd1_chk = 0;
        end
        if (frame_strobe) begin
          if (fq.size() == 0) begin
            chk("frame_unexpected", 1, 0);
          end else begin
            e = fq.pop_front();
            chk("hi_pan", c0, e.h0);
            chk("hi_tilt", c1, e.h1);
            chk("at_target", at_target, e.at);
          end
          chk("ready_upd0", cmd_ready, 0);
          upd1_chk = 1;
          c0 = int'(pwm_out[0]);
          c1 = int'(pwm_out[1]);
        end else begin
          c0 += int'(pwm_out[0]);
          c1 += int'(pwm_out[1]);
        end
        if (pend) begin
          chk("cmd_err", cmd_err, pend_e);
          pend = 0;
        end else if (cmd_err) begin
          chk("cmd_err_spurious", cmd_err, 0);
        end
        if (cmd_valid && cmd_ready) begin
          if (eq.size() == 0) begin
            chk("cmd_unexpected", 1, 0);
          end else begin
            pend   = 1;
            pend_e = eq.pop_front();
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    int n;
    rst_n      = 1'b1;
    enable     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_chan   = 1'b0;
    cmd_target = '0;
    #2 rst_n = 1'b0;
    repeat (3) nxt();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_strobe", frame_strobe, 0);
    chk("rst_at_target", at_target, 3);

    push_frame(140, 140, 2'b11);
    release_rst();
    nxt();
    nxt();
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);

    send_cmd(0, 50, 0);
    frame(140, 140, 2'b10);
    frame(160, 140, 2'b10);
    frame(180, 140, 2'b10);
    frame(200, 140, 2'b11);

    send_cmd(1, 80, 1);
    send_cmd(0, 3, 1);
    frame(200, 140, 2'b00);

    send_cmd(0, 40, 0);
    send_cmd(1, 40, 0);
    frame(180, 160, 2'b10);
    frame(160, 160, 2'b11);

    push_frame(160, 160, 2'b10);
    repeat (399) nxt();
    chk("ready_wrap", cmd_ready, 1);
    eq.push_back(0);
    cmd_valid  = 1'b1;
    cmd_chan   = 1'b0;
    cmd_target = W'(37);
    nxt();
    cmd_valid = 1'b0;
    wait_strobe(n);
    chk("wrap_align", n, 1);
    frame(148, 160, 2'b11);

    send_cmd(0, 60, 0);
    frame(148, 160, 2'b10);

    push_frame(50, 50, 2'b10);
    repeat (50) nxt();
    enable = 1'b0;
    nxt();
    chk("pwm_disable", pwm_out, 0);
    wait_strobe(n);
    frame(0, 0, 2'b10);
    nxt();
    enable = 1'b1;
    frame(167, 159, 2'b10);
    frame(188, 160, 2'b10);

    repeat (20) nxt();
    chk("pwm_mid_pulse", pwm_out, 3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_out, 0);
    chk("async_rst_at", at_target, 3);
    chk("async_rst_ready", cmd_ready, 0);
    push_frame(140, 140, 2'b11);
    repeat (3) nxt();
    release_rst();

    nxt();
    chk("frames_left", fq.size(), 0);
    chk("cmds_left", eq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/turret_servo_sequencer.md
Name: turret_servo_sequencer

Overview:
- Two-channel servo pulse controller for the turret's pan (ch0) and tilt (ch1) axes, driving the PWM and PWM_0 pins.
- Software writes target pulse widths through a valid/ready command port.
- Once per frame, the block slews each channel's current width toward its target by a bounded step.
- One shared update engine sequences both channels, so abrupt commands never jerk the mechanics.

Parameters:
- CLK_DIV, 10, SYSCLK cycles per 1 us tick (10 MHz); must be >= 3.
- FRAME_US, 20000, frame length in ticks (20 ms).
- MIN_US, 1000, minimum legal pulse width in ticks.
- MAX_US, 2000, maximum legal pulse width in ticks.
- CENTER_US, 1500, reset width for both channels.
- STEP_US, 10, maximum change of width per frame.
- W, 16, width of all pulse/counter values.

Ports:
- SYSCLK  in  1  system clock.
- NSYSRESET  in  1  asynchronous active-low reset.
- enable  in  1  1 = drive pulses and ramp; 0 = outputs low, ramp frozen.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_chan  in  1  0 = pan, 1 = tilt.
- cmd_target  in  W  requested width in ticks.
- cmd_err  out  1  one-cycle pulse: accepted target was clamped.
- pwm_out  out  2  servo pulses, bit0 = pan, bit1 = tilt.
- at_target  out  2  bit i = 1 when cur[i] == target[i].
- frame_strobe  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async, NSYSRESET=0):
  - cur[i] = target[i] = CENTER_US; prescaler = 0; frame_cnt = 0; state = IDLE.
  - pwm_out = 0, cmd_ready = 0, cmd_err = 0, frame_strobe = 0, at_target = 2'b11.
  - Deassertion takes effect at the next SYSCLK edge.
- Timebase:
  - Prescaler counts 0..CLK_DIV-1; tick = 1 on the cycle it equals CLK_DIV-1.
  - frame_cnt increments on tick and wraps FRAME_US-1 -> 0.
  - wrap = tick && frame_cnt == FRAME_US-1. frame_strobe = wrap, registered, one cycle.
  - Timebase runs regardless of enable.
- FSM IDLE -> UPD0 -> UPD1 -> IDLE:
  - IDLE: on wrap go to UPD0; otherwise stay.
  - UPD0 updates ch0 and UPD1 updates ch1, using one shared difference/step datapath.
  - If enable = 1: cur = target when |target-cur| <= STEP_US, else cur +/- STEP_US toward target. If enable = 0: cur unchanged.
  - Both updates finish before the next tick (CLK_DIV >= 3), so cur is stable for the whole pulse.
- Commands:
  - cmd_ready = (state == IDLE) after reset.
  - On valid&ready, target[cmd_chan] = clamp(cmd_target, MIN_US, MAX_US).
  - cmd_err pulses the next cycle if clamping changed the value.
  - A command accepted on the wrap cycle lands before UPD0/UPD1, so that frame uses the new target.
  - Repeated commands to the same channel: last accepted wins.
- PWM: pwm_out[i] = enable && (frame_cnt < cur[i]), registered (one-cycle latency). High time per frame = cur[i] ticks. enable = 0 forces both outputs low on the next cycle.
- at_target is combinational from registered cur/target.
- Widths are unsigned W bits. The step arithmetic uses a W+1-bit signed difference; no wrap-around is possible because values stay within [MIN_US, MAX_US].

Decomposition:
- Package turret_pkg:
  - FSM state enum (IDLE, UPD0, UPD1).
  - Channel index constants PAN = 0, TILT = 1.
  - Default width constants MIN/MAX/CENTER/STEP.
  - Clamp function.
- Sub-module pwm_frame_timer: prescaler plus frame counter; outputs tick, frame_cnt, wrap.
- FSM, shared step datapath and PWM compare stay in the top module.

Test Plan (bench overrides CLK_DIV=4, FRAME_US=100, MIN_US=10, MAX_US=60, CENTER_US=35, STEP_US=5):
- Reset release, enable=1, no commands -> each pwm_out high 35 ticks (140 SYSCLK) of every 100-tick frame; at_target=11; cmd_ready=1.
- cmd ch0 target=50 -> cur0 goes 40, 45, 50 on three successive frame_strobes; at_target[0] rises after the third; ch1 stays at 35.
- cmd ch1 target=80 -> target1=60, cmd_err pulses once. cmd ch0 target=3 -> target0=10, cmd_err pulses.
- Command driven on the wrap cycle (ch0 target=37) -> accepted, cur0=37 after that frame's UPD0; cmd_ready=0 in the two UPD cycles.
- enable=0 mid-ramp -> pwm_out=00 next cycle, cur frozen across frames; enable=1 -> ramp resumes from the frozen value.
- NSYSRESET asserted mid-pulse -> pwm_out=00 immediately (async); after release cur=35 and frame_cnt restarts at 0.
